// File: rtl/neo_frame_sequencer.sv
// rtl/neo_frame_sequencer.sv - animated frame producer feeding the NeoPixel strand controller
module neo_frame_sequencer #(
    parameter int                 NUM_PIXELS   = 5,
    parameter int                 COLOR_W      = 8,
    parameter int                 FRAME_REPEAT = 4,
    parameter logic [COLOR_W-1:0] FADE_STEP    = COLOR_W'(8'h04),
    parameter int                 PIX_W        = $clog2(NUM_PIXELS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [NUM_PIXELS-1:0] pixel_mask,
    input  logic [2:0]            chan_mask,
    input  logic [COLOR_W-1:0]    level,
    input  logic                  ready_to_load,
    input  logic                  ready_to_send,
    input  logic                  done_send,
    output logic                  load_color,
    output logic [PIX_W-1:0]      pixel_index,
    output logic [1:0]            color_index,
    output logic [COLOR_W-1:0]    color_level,
    output logic                  send_it,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int RPT_W = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STATIC = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_FADE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SEND = 2'd2,
        SENDING   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Frame registers: snapshot of the inputs taken when a frame starts
    logic [1:0]            f_mode;
    logic [NUM_PIXELS-1:0] f_pmask;
    logic [2:0]            f_cmask;
    logic [COLOR_W-1:0]    f_level;

    logic [PIX_W-1:0]      pix_idx;
    logic [1:0]            chan_idx;
    logic [RPT_W-1:0]      rep_cnt;
    logic [PIX_W-1:0]      chase_pos;
    logic [COLOR_W-1:0]    fade_lvl;
    logic                  fade_down;
    logic [COLOR_W:0]      fade_sum;
    logic [COLOR_W-1:0]    cur_level;

    logic last_load;
    logic last_rep;

    assign last_load = (pix_idx == PIX_W'(NUM_PIXELS - 1)) && (chan_idx == 2'd2);
    assign last_rep  = (rep_cnt == RPT_W'(FRAME_REPEAT - 1));
    assign fade_sum  = {1'b0, fade_lvl} + {1'b0, FADE_STEP};
    assign busy      = (state != IDLE);

    // Level for the pixel/channel currently addressed by the load index
    always_comb begin
        cur_level = '0;
        case (f_mode)
            MODE_OFF:    cur_level = '0;
            MODE_STATIC: cur_level = f_pmask[pix_idx] ? f_level : '0;
            MODE_CHASE:  cur_level = (pix_idx == chase_pos) ? f_level : '0;
            MODE_FADE:   cur_level = f_pmask[pix_idx] ? fade_lvl : '0;
            default:     cur_level = '0;
        endcase
        if (!f_cmask[chan_idx]) begin
            cur_level = '0;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; load fields read zero without a strobe
    always_comb begin
        state_nxt   = state;
        load_color  = 1'b0;
        pixel_index = '0;
        color_index = '0;
        color_level = '0;
        send_it     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ready_to_load) begin
                    load_color  = 1'b1;
                    pixel_index = pix_idx;
                    color_index = chan_idx;
                    color_level = cur_level;
                    if (last_load) begin
                        state_nxt = WAIT_SEND;
                    end
                end
            end
            WAIT_SEND: begin
                if (ready_to_send) begin
                    send_it   = 1'b1;
                    state_nxt = SENDING;
                end
            end
            SENDING: begin
                if (done_send) begin
                    state_nxt = last_rep ? IDLE : LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load index, frame snapshot, repeat counter and animation state
    always_ff @(posedge clock) begin
        if (!reset) begin
            f_mode      <= MODE_OFF;
            f_pmask     <= '0;
            f_cmask     <= '0;
            f_level     <= '0;
            pix_idx     <= '0;
            chan_idx    <= '0;
            rep_cnt     <= '0;
            chase_pos   <= '0;
            fade_lvl    <= '0;
            fade_down   <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        f_mode   <= mode;
                        f_pmask  <= pixel_mask;
                        f_cmask  <= chan_mask;
                        f_level  <= level;
                        pix_idx  <= '0;
                        chan_idx <= '0;
                    end
                end
                LOAD: begin
                    if (ready_to_load) begin
                        if (chan_idx == 2'd2) begin
                            chan_idx <= '0;
                            pix_idx  <= pix_idx + PIX_W'(1);
                        end else begin
                            chan_idx <= chan_idx + 2'd1;
                        end
                    end
                end
                SENDING: begin
                    if (done_send) begin
                        pix_idx  <= '0;
                        chan_idx <= '0;
                        if (last_rep) begin
                            rep_cnt     <= '0;
                            frame_count <= frame_count + 16'd1;
                            chase_pos   <= (chase_pos == PIX_W'(NUM_PIXELS - 1)) ?
                                           '0 : chase_pos + PIX_W'(1);
                            // Triangle wave between 0 and the latched level
                            if (f_level == '0) begin
                                fade_lvl <= '0;
                            end else if (!fade_down) begin
                                if (fade_sum >= {1'b0, f_level}) begin
                                    fade_lvl  <= f_level;
                                    fade_down <= 1'b1;
                                end else begin
                                    fade_lvl <= fade_sum[COLOR_W-1:0];
                                end
                            end else begin
                                if (fade_lvl <= FADE_STEP) begin
                                    fade_lvl  <= '0;
                                    fade_down <= 1'b0;
                                end else begin
                                    fade_lvl <= fade_lvl - FADE_STEP;
                                end
                            end
                        end else begin
                            rep_cnt <= rep_cnt + RPT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// tb/tb_neo_frame_sequencer.sv - directed self-checking bench for neo_frame_sequencer
module tb_neo_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [4:0]  pixel_mask;
    logic [2:0]  chan_mask;
    logic [7:0]  level;
    logic        ready_to_load;
    logic        ready_to_send;
    logic        done_send;
    logic        load_color;
    logic [2:0]  pixel_index;
    logic [1:0]  color_index;
    logic [7:0]  color_level;
    logic        send_it;
    logic        busy;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] nxt_mode;
    logic [4:0] nxt_pmask;
    logic [2:0] nxt_cmask;
    logic [7:0] nxt_level;
    logic       nxt_en;

    always #5 clock = ~clock;

    neo_frame_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .mode          (mode),
        .pixel_mask    (pixel_mask),
        .chan_mask     (chan_mask),
        .level         (level),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .done_send     (done_send),
        .load_color    (load_color),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .send_it       (send_it),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        done_send     = 1'b0;
        @(negedge clock);
        #1;
        check("rst_load_color", load_color, 1'b0);
        check("rst_send_it", send_it, 1'b0);
        @(negedge clock);
        #1;
        check("rst_load_color2", load_color, 1'b0);
        check("rst_pixel_index", pixel_index, 3'd0);
        check("rst_color_index", color_index, 2'd0);
        check("rst_color_level", color_level, 8'h00);
        check("rst_send_it2", send_it, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic load_phase(input logic [4:0] lit, input logic [2:0] cm, input logic [7:0] val,
                              input int n_loads, input int stall_at, input int stall_len,
                              input bit apply_chg, output int nz);
        int k = 0;
        int cyc = 0;
        int stalled = 0;
        int p;
        int c;
        logic rtl;
        logic [7:0] ev;
        nz = 0;
        while (k < n_loads && cyc < 200) begin
            @(negedge clock);
            rtl           = !(k == stall_at && stalled < stall_len);
            ready_to_load = rtl;
            ready_to_send = 1'b0;
            done_send     = 1'b0;
            if (apply_chg && k == 5) begin
                mode       = nxt_mode;
                pixel_mask = nxt_pmask;
                chan_mask  = nxt_cmask;
                level      = nxt_level;
                enable     = nxt_en;
            end
            #1;
            check("load_color", load_color, rtl);
            if (rtl) begin
                p  = k / 3;
                c  = k % 3;
                ev = (lit[p] && cm[c]) ? val : 8'h00;
                check("pixel_index", pixel_index, p);
                check("color_index", color_index, c);
                check("color_level", color_level, ev);
                if (color_level != 8'h00) nz++;
                k++;
            end else begin
                stalled++;
                check("stall_pixel_index", pixel_index, 3'd0);
                check("stall_color_level", color_level, 8'h00);
            end
            cyc++;
        end
        if (cyc >= 200) check("load_timeout", 0, 1);
        ready_to_load = 1'b1;
    endtask

    task automatic send_phase(input bit early);
        @(negedge clock);
        ready_to_send = 1'b1;
        done_send     = early;
        #1;
        check("send_it", send_it, 1'b1);
        check("send_no_load", load_color, 1'b0);
        check("send_busy", busy, 1'b1);
        @(negedge clock);
        done_send = 1'b0;
        #1;
        check("send_once", send_it, 1'b0);
        if (early) begin
            @(negedge clock);
            #1;
            check("early_done_ignored", load_color, 1'b0);
            check("early_busy", busy, 1'b1);
        end
        @(negedge clock);
        ready_to_send = 1'b0;
        done_send     = 1'b1;
        #1;
        check("wait_done_send", send_it, 1'b0);
        @(posedge clock);
        #1;
        done_send = 1'b0;
    endtask

    task automatic run_frame(input logic [4:0] lit, input logic [2:0] cm, input logic [7:0] val,
                             input int stall_at, input int stall_len, input bit apply_chg,
                             input int exp_nz, input int exp_fc);
        int nz;
        @(negedge clock);
        ready_to_load = 1'b1;
        done_send     = 1'b0;
        #1;
        check("idle_no_load", load_color, 1'b0);
        check("idle_busy", busy, 1'b0);
        for (int r = 0; r < 4; r++) begin
            load_phase(lit, cm, val, 15, (r == 0) ? stall_at : -1, stall_len, apply_chg && (r == 0), nz);
            check("nonzero_loads", nz, exp_nz);
            send_phase(1'b0);
        end
        check("frame_count", frame_count, exp_fc);
        check("end_busy", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] fade_tab [8];
        int nz;
        fade_tab = '{8'h00, 8'h04, 8'h08, 8'h0A, 8'h06, 8'h02, 8'h00, 8'h04};
        reset         = 1'b0;
        enable        = 1'b0;
        mode          = 2'd0;
        pixel_mask    = 5'b0;
        chan_mask     = 3'b0;
        level         = 8'h00;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        done_send     = 1'b0;
        nxt_mode      = 2'd0;
        nxt_pmask     = 5'b0;
        nxt_cmask     = 3'b0;
        nxt_level     = 8'h00;
        nxt_en        = 1'b0;

        do_reset();

        mode       = 2'd1;
        pixel_mask = 5'b10101;
        chan_mask  = 3'b010;
        level      = 8'h20;
        enable     = 1'b1;
        run_frame(5'b10101, 3'b010, 8'h20, -1, 0, 1'b0, 3, 1);
        run_frame(5'b10101, 3'b010, 8'h20, 7, 3, 1'b0, 3, 2);

        do_reset();
        mode       = 2'd2;
        pixel_mask = 5'b00000;
        chan_mask  = 3'b111;
        level      = 8'h33;
        for (int i = 0; i < 5; i++) begin
            run_frame(5'b00001 << i, 3'b111, 8'h33, -1, 0, 1'b0, 3, i + 1);
        end
        nxt_mode  = 2'd1;
        nxt_pmask = 5'b00011;
        nxt_cmask = 3'b100;
        nxt_level = 8'h11;
        nxt_en    = 1'b1;
        run_frame(5'b00001, 3'b111, 8'h33, -1, 0, 1'b1, 3, 6);
        nxt_mode  = 2'd2;
        nxt_pmask = 5'b11111;
        nxt_cmask = 3'b111;
        nxt_level = 8'hFF;
        nxt_en    = 1'b0;
        run_frame(5'b00011, 3'b100, 8'h11, -1, 0, 1'b1, 2, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            check("disabled_busy", busy, 1'b0);
            check("disabled_load", load_color, 1'b0);
        end
        check("disabled_frame_count", frame_count, 16'd7);

        do_reset();
        mode       = 2'd3;
        pixel_mask = 5'b01110;
        chan_mask  = 3'b001;
        level      = 8'h0A;
        enable     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_frame(5'b01110, 3'b001, fade_tab[i], -1, 0, 1'b0, (fade_tab[i] != 8'h00) ? 3 : 0, i + 1);
        end

        mode       = 2'd1;
        pixel_mask = 5'b11111;
        chan_mask  = 3'b111;
        level      = 8'h5A;
        @(negedge clock);
        #1;
        check("pre_early_busy", busy, 1'b0);
        load_phase(5'b11111, 3'b111, 8'h5A, 15, -1, 0, 1'b0, nz);
        check("full_loads", nz, 15);
        send_phase(1'b1);
        load_phase(5'b11111, 3'b111, 8'h5A, 4, -1, 0, 1'b0, nz);
        do_reset();
        run_frame(5'b11111, 3'b111, 8'h5A, -1, 0, 1'b0, 15, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
